addsub_arbiter: RTL and testbench



---
 rtl/addsub_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/sumador_restador.sv | 21 ++
 rtl/addsub_arbiter.sv | 114 +++++++++++
 tb/tb_addsub_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_arbiter shared types: FSM state, op encoding, captured control.
// Overflow helper is used only when ADDSUB_ARB_OVF_EN is defined.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic op;
    logic id;
  } ctl_t;

  // Subtract flips the sign test on b because b enters inverted.
  function automatic logic add_ovf(
    input logic op,
    input logic am,
    input logic bm,
    input logic rm
  );
    logic same;
    same = (op == OP_SUB) ? (am != bm) : (am == bm);
    return same && (rm != am);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with its own last-grant pointer.
// Pointer resets to 1 so requester 0 wins the first contest.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1])
        gnt = last ? 2'b01 : 2'b10;
      else if (req[0])
        gnt = 2'b01;
      else if (req[1])
        gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (|gnt)
      last <= gnt[1];
  end

endmodule

// File: rtl/sumador_restador.sv
// Shared adder/subtractor: {cout,res} = a + (s ? ~b : b) + s.
// For subtract, cout = 1 means no borrow.
module sumador_restador #(
  parameter int BITS = 4
) (
  input  logic            s,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] res,
  output logic            cout
);

  logic [BITS-1:0] bx;

  assign bx = s ? ~b : b;

  assign {cout, res} = {1'b0, a}
                     + {1'b0, bx}
                     + {{BITS{1'b0}}, s};

endmodule

// File: rtl/addsub_arbiter.sv
// Two requesters share one add/sub datapath: IDLE grant, EXEC, RESP hold.
// Define ADDSUB_ARB_OVF_EN to compute ovf; otherwise ovf is tied to 0.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_op,
  input  logic [BITS-1:0] req_a0,
  input  logic [BITS-1:0] req_b0,
  input  logic [BITS-1:0] req_a1,
  input  logic [BITS-1:0] req_b1,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [BITS-1:0] res,
  output logic            cout,
  output logic            ovf
);

  state_t          state;
  ctl_t            ctl;
  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic [1:0]      gnt;
  logic            arb_en;
  logic [BITS-1:0] sum;
  logic            co;
  logic            ov;

  // Gate on rst so nothing is handshaken while reset is held.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req_ready = gnt;

  sumador_restador #(
    .BITS (BITS)
  ) u_sr (
    .s    (ctl.op),
    .a    (a_q),
    .b    (b_q),
    .res  (sum),
    .cout (co)
  );

`ifdef ADDSUB_ARB_OVF_EN
  assign ov = add_ovf(ctl.op,
                      a_q[BITS-1],
                      b_q[BITS-1],
                      sum[BITS-1]);
`else
  assign ov = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctl        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      res        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            ctl.id <= gnt[1];
            if (gnt[1]) begin
              ctl.op <= req_op[1];
              a_q    <= req_a1;
              b_q    <= req_b1;
            end else begin
              ctl.op <= req_op[0];
              a_q    <= req_a0;
              b_q    <= req_b0;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          res        <= sum;
          cout       <= co;
          ovf        <= ov;
          resp_id    <= ctl.id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed cases then random traffic.
// Reference model works from plain integer arithmetic and arbitration rules.
module tb_addsub_arbiter;

  localparam int BITS = 4;
  localparam int M    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_op = 2'b00;
  logic [BITS-1:0] req_a0 = '0;
  logic [BITS-1:0] req_b0 = '0;
  logic [BITS-1:0] req_a1 = '0;
  logic [BITS-1:0] req_b1 = '0;
  logic            resp_ready = 1'b1;
  logic [1:0]      req_ready;
  logic            resp_valid;
  logic            resp_id;
  logic [BITS-1:0] res;
  logic            cout;
  logic            ovf;

  addsub_arbiter #(.BITS(BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .res        (res),
    .cout       (cout),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit id;
    int res;
    bit cout;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   busy = 0;
  int   acc_cyc = 0;
  bit   last = 1;
  bit   tmo = 0;

  function automatic exp_t model(bit id, bit op, int a, int b);
    exp_t e;
    int sa, sb, r;
    e.id = id;
    if (op) begin
      e.res  = (a - b + M) % M;
      e.cout = (a >= b);
    end else begin
      e.res  = (a + b) % M;
      e.cout = (a + b) >= M;
    end
    sa = (a >= M/2) ? a - M : a;
    sb = (b >= M/2) ? b - M : b;
    r  = op ? sa - sb : sa + sb;
`ifdef ADDSUB_ARB_OVF_EN
    e.ovf = (r < -M/2) || (r > M/2 - 1);
`else
    e.ovf = 1'b0;
    if (r == 0) e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  // Monitor: model of arbitration, latency and results.
  always @(negedge clk or posedge rst) begin
    logic [1:0] er;
    bit         gi;
    exp_t       e;
    if (rst) begin
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_req_ready", req_ready, 0);
      q.delete();
      busy = 0;
      last = 1;
    end else begin
      cyc++;
      if (tmo) chk("accept_timeout", 1, 0);
      er = 2'b00;
      if (!busy) begin
        if (req_valid == 2'b11) er = last ? 2'b01 : 2'b10;
        else er = req_valid;
      end
      chk("req_ready", req_ready, er);
      if (!busy) begin
        chk("resp_valid_idle", resp_valid, 0);
        if (er != 2'b00) begin
          gi = er[1];
          q.push_back(model(gi, req_op[gi],
                            gi ? int'(req_a1) : int'(req_a0),
                            gi ? int'(req_b1) : int'(req_b0)));
          busy    = 1;
          acc_cyc = cyc;
          last    = gi;
        end
      end else begin
        chk("resp_valid", resp_valid, int'(cyc >= acc_cyc + 2));
        if (resp_valid && q.size() > 0) begin
          e = q[0];
          chk("resp_id", resp_id, e.id);
          chk("res", res, e.res);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          if (resp_ready) begin
            void'(q.pop_front());
            busy = 0;
          end
        end
      end
    end
  end

  task automatic tick(output logic [1:0] got);
    @(negedge clk);
    got = req_ready & req_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~got;
  endtask

  task automatic set_ops(int i, bit op, int a, int b);
    req_op[i] = op;
    if (i == 0) begin
      req_a0 = BITS'(a);
      req_b0 = BITS'(b);
    end else begin
      req_a1 = BITS'(a);
      req_b1 = BITS'(b);
    end
    req_valid[i] = 1'b1;
  endtask

  task automatic issue(int i, bit op, int a, int b);
    logic [1:0] g;
    set_ops(i, op, a, b);
    for (int k = 0; k < 40 && req_valid[i]; k++) tick(g);
    if (req_valid[i]) begin
      tmo = 1;
      tick(g);
      tmo = 0;
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic idle(int n);
    logic [1:0] g;
    for (int k = 0; k < n; k++) tick(g);
  endtask

  initial begin
    logic [1:0] g;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resp_ready = 1'b1;

    issue(0, 1'b0, 3, 5);
    idle(4);
    issue(1, 1'b1, 2, 5);
    idle(4);
    issue(0, 1'b1, 5, 2);
    idle(4);

    // Fairness from a fresh reset, both requesters always valid.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    set_ops(0, 1'b0, 7, 1);
    set_ops(1, 1'b1, 1, 7);
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      tick(g);
      if (g != 2'b00) n++;
      if (n < 4 && g[0]) set_ops(0, 1'($urandom), $urandom % M, $urandom % M);
      if (n < 4 && g[1]) set_ops(1, 1'($urandom), $urandom % M, $urandom % M);
    end
    for (int k = 0; k < 20 && req_valid != 2'b00; k++) tick(g);
    idle(4);

    // Back-pressure in RESP with requester 1 waiting.
    resp_ready = 1'b0;
    issue(0, 1'b0, 9, 9);
    set_ops(1, 1'b1, 4, 12);
    idle(7);
    resp_ready = 1'b1;
    for (int k = 0; k < 20 && req_valid[1]; k++) tick(g);
    idle(4);

    // Reset while the request is in EXEC.
    issue(1, 1'b0, 6, 6);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    for (int k = 0; k < 400; k++) begin
      resp_ready = 1'($urandom % 2);
      for (int i = 0; i < 2; i++)
        if (!req_valid[i] && ($urandom % 3) == 0)
          set_ops(i, 1'($urandom), $urandom % M, $urandom % M);
      tick(g);
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 40 && req_valid != 2'b00; k++) tick(g);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
